// File: rtl/dma_if_rd_credit_arb.sv
`default_nettype none
// ============================================================================
// Module   : dma_if_rd_credit_arb
// Brief    : Round-robin credit-limited scheduler of PORTS read descriptor
//            clients onto one DMA read descriptor channel, with status routing.
//            Optional macro DMA_RD_CREDIT_ARB_STATS_EN adds stat_issued.
// Revision : 1.0 - initial release
// ============================================================================
module dma_if_rd_credit_arb #(
   parameter int PORTS           = 2,
   parameter int DMA_ADDR_WIDTH  = 64,
   parameter int RAM_SEL_WIDTH   = 2,
   parameter int RAM_ADDR_WIDTH  = 16,
   parameter int LEN_WIDTH       = 16,
   parameter int S_TAG_WIDTH     = 8,
   parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,

   input  logic [PORTS*DMA_ADDR_WIDTH-1:0]     s_axis_read_desc_dma_addr,
   input  logic [PORTS*RAM_SEL_WIDTH-1:0]      s_axis_read_desc_ram_sel,
   input  logic [PORTS*RAM_ADDR_WIDTH-1:0]     s_axis_read_desc_ram_addr,
   input  logic [PORTS*LEN_WIDTH-1:0]          s_axis_read_desc_len,
   input  logic [PORTS*S_TAG_WIDTH-1:0]        s_axis_read_desc_tag,
   input  logic [PORTS-1:0]                    s_axis_read_desc_valid,
   output logic [PORTS-1:0]                    s_axis_read_desc_ready,

   output logic [DMA_ADDR_WIDTH-1:0]           m_axis_read_desc_dma_addr,
   output logic [RAM_SEL_WIDTH-1:0]            m_axis_read_desc_ram_sel,
   output logic [RAM_ADDR_WIDTH-1:0]           m_axis_read_desc_ram_addr,
   output logic [LEN_WIDTH-1:0]                m_axis_read_desc_len,
   output logic [M_TAG_WIDTH-1:0]              m_axis_read_desc_tag,
   output logic                                m_axis_read_desc_valid,
   input  logic                                m_axis_read_desc_ready,

   input  logic [M_TAG_WIDTH-1:0]              s_axis_read_desc_status_tag,
   input  logic [3:0]                          s_axis_read_desc_status_error,
   input  logic                                s_axis_read_desc_status_valid,

   output logic [PORTS*S_TAG_WIDTH-1:0]        m_axis_read_desc_status_tag,
   output logic [PORTS*4-1:0]                  m_axis_read_desc_status_error,
   output logic [PORTS-1:0]                    m_axis_read_desc_status_valid,

   output logic [PORTS*CNT_WIDTH-1:0]          outstanding,
`ifdef DMA_RD_CREDIT_ARB_STATS_EN
   output logic [PORTS*32-1:0]                 stat_issued,
`endif
   output logic                                status_err
);

   localparam int C_PORT_W = $clog2(PORTS);

   // Wrap-around port index addition, used to rotate the round-robin start.
   function automatic logic [C_PORT_W-1:0] port_add(input logic [C_PORT_W-1:0] base,
                                                     input int                  off);
      int sum;
      sum = int'(32'(base)) + off;
      if (sum >= PORTS) begin
         sum = sum - PORTS;
      end
      return C_PORT_W'(sum);
   endfunction

   // ---------------------------------------------------------------- state
   logic                        m_valid_q,  m_valid_d;
   logic [DMA_ADDR_WIDTH-1:0]   m_addr_q,   m_addr_d;
   logic [RAM_SEL_WIDTH-1:0]    m_sel_q,    m_sel_d;
   logic [RAM_ADDR_WIDTH-1:0]   m_raddr_q,  m_raddr_d;
   logic [LEN_WIDTH-1:0]        m_len_q,    m_len_d;
   logic [M_TAG_WIDTH-1:0]      m_tag_q,    m_tag_d;
   logic [C_PORT_W-1:0]         rr_q,       rr_d;
   logic [CNT_WIDTH-1:0]        cnt_q [PORTS];
   logic [CNT_WIDTH-1:0]        cnt_d [PORTS];
   logic [PORTS-1:0]            st_valid_q, st_valid_d;
   logic [PORTS*S_TAG_WIDTH-1:0] st_tag_q,  st_tag_d;
   logic [PORTS*4-1:0]          st_err_q,   st_err_d;
   logic                        serr_q,     serr_d;

   // ---------------------------------------------------------------- arbitration
   logic [PORTS-1:0]            elig;
   logic                        grant_found;
   logic [C_PORT_W-1:0]         grant_idx;
   logic                        out_free;
   logic                        accept;
   logic [PORTS-1:0]            inc;

   assign out_free = !m_valid_q || m_axis_read_desc_ready;
   assign accept   = grant_found && out_free;

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         elig[i] = s_axis_read_desc_valid[i] && enable &&
                   (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
      end
   end

   // First eligible port at or after rr_q wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < PORTS; k++) begin
         if (!grant_found && elig[port_add(rr_q, k)]) begin
            grant_found = 1'b1;
            grant_idx   = port_add(rr_q, k);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         inc[i]                    = accept && (grant_idx == C_PORT_W'(i));
         s_axis_read_desc_ready[i] = inc[i];
      end
   end

   // ---------------------------------------------------------------- descriptor mux
   logic [DMA_ADDR_WIDTH-1:0]   sel_addr;
   logic [RAM_SEL_WIDTH-1:0]    sel_sel;
   logic [RAM_ADDR_WIDTH-1:0]   sel_raddr;
   logic [LEN_WIDTH-1:0]        sel_len;
   logic [S_TAG_WIDTH-1:0]      sel_tag;

   always_comb begin
      sel_addr  = '0;
      sel_sel   = '0;
      sel_raddr = '0;
      sel_len   = '0;
      sel_tag   = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant_idx == C_PORT_W'(i)) begin
            sel_addr  = s_axis_read_desc_dma_addr[i*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
            sel_sel   = s_axis_read_desc_ram_sel[i*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
            sel_raddr = s_axis_read_desc_ram_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            sel_len   = s_axis_read_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
            sel_tag   = s_axis_read_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------- status decode
   logic [C_PORT_W-1:0]         st_port;
   logic [PORTS-1:0]            st_dec;
   logic                        st_miss;

   assign st_port = s_axis_read_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];

   // A port index beyond PORTS-1 matches no entry and falls into st_miss.
   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         st_dec[i] = s_axis_read_desc_status_valid && (st_port == C_PORT_W'(i)) &&
                     (cnt_q[i] != '0);
      end
   end

   assign st_miss = s_axis_read_desc_status_valid && !(|st_dec);

   // ---------------------------------------------------------------- next state
   always_comb begin
      m_valid_d  = m_valid_q;
      m_addr_d   = m_addr_q;
      m_sel_d    = m_sel_q;
      m_raddr_d  = m_raddr_q;
      m_len_d    = m_len_q;
      m_tag_d    = m_tag_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      st_valid_d = st_dec;
      st_tag_d   = st_tag_q;
      st_err_d   = st_err_q;
      serr_d     = serr_q | st_miss;

      if (accept) begin
         m_valid_d = 1'b1;
         m_addr_d  = sel_addr;
         m_sel_d   = sel_sel;
         m_raddr_d = sel_raddr;
         m_len_d   = sel_len;
         m_tag_d   = {grant_idx, sel_tag};
         rr_d      = port_add(grant_idx, 1);
      end else if (m_axis_read_desc_ready) begin
         m_valid_d = 1'b0;
      end

      for (int i = 0; i < PORTS; i++) begin
         if (st_dec[i]) begin
            st_tag_d[i*S_TAG_WIDTH +: S_TAG_WIDTH] =
               s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
            st_err_d[i*4 +: 4] = s_axis_read_desc_status_error;
         end
         // Accept and completion on the same port cancel out.
         if (inc[i] && !st_dec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end else if (!inc[i] && st_dec[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
         end
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q  <= 1'b0;
         m_addr_q   <= '0;
         m_sel_q    <= '0;
         m_raddr_q  <= '0;
         m_len_q    <= '0;
         m_tag_q    <= '0;
         rr_q       <= '0;
         st_valid_q <= '0;
         st_tag_q   <= '0;
         st_err_q   <= '0;
         serr_q     <= 1'b0;
         for (int i = 0; i < PORTS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         m_valid_q  <= m_valid_d;
         m_addr_q   <= m_addr_d;
         m_sel_q    <= m_sel_d;
         m_raddr_q  <= m_raddr_d;
         m_len_q    <= m_len_d;
         m_tag_q    <= m_tag_d;
         rr_q       <= rr_d;
         st_valid_q <= st_valid_d;
         st_tag_q   <= st_tag_d;
         st_err_q   <= st_err_d;
         serr_q     <= serr_d;
         for (int i = 0; i < PORTS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign m_axis_read_desc_dma_addr     = m_addr_q;
   assign m_axis_read_desc_ram_sel      = m_sel_q;
   assign m_axis_read_desc_ram_addr     = m_raddr_q;
   assign m_axis_read_desc_len          = m_len_q;
   assign m_axis_read_desc_tag          = m_tag_q;
   assign m_axis_read_desc_valid        = m_valid_q;
   assign m_axis_read_desc_status_tag   = st_tag_q;
   assign m_axis_read_desc_status_error = st_err_q;
   assign m_axis_read_desc_status_valid = st_valid_q;
   assign status_err                    = serr_q;

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

`ifdef DMA_RD_CREDIT_ARB_STATS_EN
   logic [31:0] stat_q [PORTS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PORTS; i++) begin
            stat_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (inc[i]) begin
               stat_q[i] <= stat_q[i] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         stat_issued[i*32 +: 32] = stat_q[i];
      end
   end
`endif

endmodule
`default_nettype wire
